// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if: L1 pmem sides plus L2 mem side of the shared L2 port
interface l2_port_arbiter_if;
  logic         i_read;
  logic [31:0]  i_addr;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] l1_rdata;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_addr;
  logic [255:0] l2_wdata;
  logic         l2_resp;
  logic [255:0] l2_rdata;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
    output i_resp, d_resp, l1_rdata, l2_read, l2_write, l2_addr, l2_wdata
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_resp, l2_rdata,
    input  i_resp, d_resp, l1_rdata, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin arbiter of the shared L2 port between I and D caches
module l2_port_arbiter #(
  parameter int CNT_WIDTH = 16,
  parameter bit D_FIRST   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_port_arbiter_if.slave     bus,
  output logic [CNT_WIDTH-1:0] i_grants,
  output logic [CNT_WIDTH-1:0] d_grants
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  logic [1:0]  state;
  logic        last_d;
  logic        d_req;
  logic        pick_d;
  logic [31:0] grant_addr;
  always_comb begin
    d_req        = bus.d_read | bus.d_write;
    pick_d       = d_req && (!bus.i_read || !last_d);
    grant_addr   = pick_d ? bus.d_addr : bus.i_addr;
    bus.i_resp   = (state == SERVE_I) && bus.l2_resp;
    bus.d_resp   = (state == SERVE_D) && bus.l2_resp;
    bus.l1_rdata = bus.l2_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_d       <= !D_FIRST;
      bus.l2_read  <= 1'b0;
      bus.l2_write <= 1'b0;
      bus.l2_addr  <= '0;
      bus.l2_wdata <= '0;
      i_grants     <= '0;
      d_grants     <= '0;
    end else if (state == IDLE) begin
      if (bus.i_read || d_req) begin
        state        <= pick_d ? SERVE_D : SERVE_I;
        bus.l2_addr  <= grant_addr & ~32'h1f;
        bus.l2_read  <= !(pick_d && bus.d_write);
        bus.l2_write <= pick_d && bus.d_write;
        if (pick_d && bus.d_write) bus.l2_wdata <= bus.d_wdata;
      end
    end else if (bus.l2_resp) begin
      state        <= IDLE;
      last_d       <= (state == SERVE_D);
      bus.l2_read  <= 1'b0;
      bus.l2_write <= 1'b0;
      if (state == SERVE_I && i_grants != '1) i_grants <= i_grants + 1'b1;
      if (state == SERVE_D && d_grants != '1) d_grants <= d_grants + 1'b1;
    end
  end
endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Arbitrates the single 256-bit L2 cache port between the L1 instruction cache (read-only line fills) and the L1 data cache (line fills and write-backs). Sits between the two L1 `pmem_*` sides and the L2 `mem_*` side inside the cache top. It provides the following:
- Grants one requester at a time, using round-robin on ties.
- Registers the L2 request for the whole transaction.
- Routes `l2_resp` and the line data back to the granted requester only.
- Keeps saturating grant counters for performance analysis.

## Interface
- `CNT_WIDTH`, 16: width of each saturating grant counter.
- `D_FIRST`, 1: tie-break owner after reset (1 = D cache wins first tie, 0 = I cache).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_read`  in  1  I-cache line-fill request; held until `i_resp`.
- `i_addr`  in  32  I-cache line address.
- `i_resp`  out  1  one-cycle completion pulse to the I cache.
- `d_read`  in  1  D-cache line-fill request; held until `d_resp`.
- `d_write`  in  1  D-cache write-back request; held until `d_resp`.
- `d_addr`  in  32  D-cache line address.
- `d_wdata`  in  256  D-cache write-back line.
- `d_resp`  out  1  one-cycle completion pulse to the D cache.
- `l1_rdata`  out  256  fill line, shared by both L1s.
- `l2_read`  out  1  L2 read request (registered).
- `l2_write`  out  1  L2 write request (registered).
- `l2_addr`  out  32  L2 address (registered; bits [4:0] always 0).
- `l2_wdata`  out  256  L2 write line (registered).
- `l2_resp`  in  1  L2 completion pulse.
- `l2_rdata`  in  256  L2 read line.
- `i_grants`  out  CNT_WIDTH  completed I transactions (saturating).
- `d_grants`  out  CNT_WIDTH  completed D transactions (saturating).

## Operation

FSM states: IDLE, SERVE_I, SERVE_D.

**IDLE**
- I pending only -> SERVE_I.
- D pending only (`d_read | d_write`) -> SERVE_D.
- Both pending -> the requester that was not served last. `last_served` resets to I if `D_FIRST`=1, otherwise to D.
- On the grant edge, latch into output registers:
  - `l2_addr` = {addr[31:5], 5'b0}.
  - `l2_wdata` = `d_wdata` (D write-back only).
  - The `l2_read` or `l2_write` strobe.
- If `d_read` and `d_write` are both high (illegal), treat it as a write.

**SERVE_x**
- Latched outputs hold constant; requester inputs are ignored.
- On `l2_resp`:
  - Pulse `x_resp` (combinational, same cycle).
  - Update `last_served` = x.
  - Increment `x_grants` unless it is all-ones.
  - Clear the strobes.
  - Return to IDLE.
- A requester dropping its request mid-transaction does not abort it: the L2 access completes and `x_resp` still pulses.

**Response and data routing**
- `l1_rdata` = `l2_rdata` passed through combinationally in all states. Each L1 qualifies it with its own resp.
- `i_resp`/`d_resp` are never asserted outside SERVE_I/SERVE_D. They are never asserted simultaneously.
- An `l2_resp` seen in IDLE is ignored.

**L1 contract:** a requester deasserts its request in the cycle after its resp. The arbiter does not detect a violation; a held request is re-granted as a new transaction.

## Timing
- **Reset values:** state=IDLE; `l2_read`=`l2_write`=0; `l2_addr`=0; `l2_wdata`=0; `i_resp`=`d_resp`=0; counters=0.
- **Reset mid-transaction:** state returns to IDLE next edge and strobes drop. The outstanding L2 access is abandoned and no resp is given.
- **Grant latency:** request first high at cycle t (state IDLE) -> `l2_read`/`l2_write` high from cycle t+1.
- **Completion:** `l2_resp` at cycle k -> `x_resp`=1 at k only. Strobes are 0 from k+1 and state is IDLE at k+1.
- **Back-to-back:** a request pending at k+1 is granted with L2 strobe at k+2. Minimum one idle L2 cycle between transactions.
- **Strobe stability:** strobe, address and wdata never change between grant and `l2_resp`.
- **Fairness:** with both requesters continuously pending, grants strictly alternate. Worst-case wait is one full transaction of the other requester.

## Test plan
- **Single I fill:** `i_read`=1, `i_addr`=0x0000_1234 at t. Required:
  - `l2_read`=1 and `l2_addr`=0x0000_1220 at t+1.
  - L2 returns `l2_resp` at t+5 with `l2_rdata`=0xA5…A5 -> `i_resp`=1 at t+5 only, `l1_rdata`=0xA5…A5, `d_resp`=0.
  - `i_grants`=1.
- **D write-back:** `d_write`=1, `d_addr`=0x8000_0040, `d_wdata`=0x1234…. Required:
  - `l2_write`=1 and `l2_wdata` equal to that line from grant to resp.
  - `d_resp` pulses once; `d_grants`=1.
- **Simultaneous requests after reset (`D_FIRST`=1):** `i_read` and `d_read` both held high. Required grant order D, I, D, I; counters read 2/2 after four completions.
- **Request change mid-transaction:** during SERVE_D, change `d_addr` and drop `d_read`. Required:
  - `l2_addr` unchanged.
  - `d_resp` still pulses on `l2_resp`.
  - No I grant before the next IDLE cycle.
- **Reset mid-transaction:** assert `rst` for one cycle in SERVE_I. Required:
  - Next cycle all outputs are at reset values.
  - A subsequent `l2_resp` produces no `i_resp`.
- **Saturation and illegal request:** run with `CNT_WIDTH`=2 and do 5 I fills. Required `i_grants`=3. Then drive `d_read`=`d_write`=1; required `l2_write`=1 and `l2_read`=0.
